// File: rtl/if_id_stage.sv
// IF stage + IF/ID register: 1-cycle fetch from writable imem, jump flush inserts one bubble, stall holds.
// Optional IF_PERF_CNT_EN adds saturating fetch/flush counters; no backpressure beyond the stall input.
module if_id_stage #(
  parameter int INSTR_W = 8,
  parameter int PC_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               jump_ID,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               imem_we,
  input  logic [PC_W-1:0]    imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  output logic [INSTR_W-1:0] instr_IF_ID,
  output logic [1:0]         opcode_IF_ID,
  output logic [PC_W-1:0]    pc_IF_ID,
  output logic               valid_IF_ID,
  output logic [PC_W-1:0]    pc_IF
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]        fetch_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  logic [INSTR_W-1:0] r_imem [2**PC_W];
  logic [INSTR_W-1:0] r_instr;
  logic [1:0]         r_opcode;
  logic [PC_W-1:0]    r_pc_id;
  logic               r_valid;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] w_instr;

  // Combinational read sees the pre-write word when write and fetch collide.
  assign w_instr = r_imem[r_pc];

  always_ff @(posedge clk) begin
    if (imem_we) begin
      r_imem[imem_waddr] <= imem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc     <= '0;
      r_instr  <= '0;
      r_opcode <= '0;
      r_pc_id  <= '0;
      r_valid  <= 1'b0;
    end else if (jump_ID) begin
      // Flush leaves pc_IF_ID untouched; only the valid bit marks the bubble.
      r_pc     <= jump_target;
      r_instr  <= '0;
      r_opcode <= '0;
      r_valid  <= 1'b0;
    end else if (!stall) begin
      r_instr  <= w_instr;
      r_opcode <= w_instr[INSTR_W-1 -: 2];
      r_pc_id  <= r_pc;
      r_valid  <= 1'b1;
      r_pc     <= r_pc + PC_W'(1);
    end
  end

  assign instr_IF_ID  = r_instr;
  assign opcode_IF_ID = r_opcode;
  assign pc_IF_ID     = r_pc_id;
  assign valid_IF_ID  = r_valid;
  assign pc_IF        = r_pc;

`ifdef IF_PERF_CNT_EN
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (jump_ID) begin
      if (r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
    end else if (!stall) begin
      if (r_fetch_cnt != 16'hFFFF) r_fetch_cnt <= r_fetch_cnt + 16'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule
